// File: rtl/code_lock_fsm_pkg.sv
// lock_pkg: state encodings and code-width helper shared by the code lock
package lock_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ENTRY     = 3'd1,
    S_OPENED    = 3'd2,
    S_ALARM     = 3'd3,
    S_SET_ENTRY = 3'd4,
    S_LOCKOUT   = 3'd5
  } state_t;

  function automatic int code_w(input int code_len, input int digit_w);
    return code_len * digit_w;
  endfunction

endpackage

// File: rtl/code_lock_fsm_blink_timer.sv
// blink_timer: free-running blink counter plus loadable lockout down-counter
module blink_timer #(
  parameter int CNT_W = 9,
  parameter int TMR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             en,
  output logic             blink_nxt,
  output logic             tmr_zero
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [TMR_W-1:0] tmr;

  assign cnt_inc   = cnt + CNT_W'(1);
  assign blink_nxt = cnt_inc[CNT_W-1];
  assign tmr_zero  = tmr == '0;

  // Blink counter wraps freely; lockout timer loads then counts down to zero and holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      tmr <= '0;
    end else begin
      cnt <= cnt_inc;
      tmr <= load ? load_val : (en && !tmr_zero) ? tmr - TMR_W'(1) : tmr;
    end
  end

endmodule

// File: rtl/code_lock_fsm.sv
// code_lock_fsm: multi-digit code lock with code change, retry counting, timed lockout and blinking alarm
module code_lock_fsm
  import lock_pkg::*;
#(
  parameter int DIGIT_W        = 7,
  parameter int CODE_LEN       = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 65536,
  parameter int BLINK_BIT      = 8,
  parameter logic [CODE_LEN*DIGIT_W-1:0] RESET_CODE = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DIGIT_W-1:0]             digit_in,
  input  logic                           check_btn,
  input  logic                           set_btn,
  output logic                           opened,
  output logic                           alarm,
  output logic                           locked_out,
  output logic [2:0]                     state,
  output logic [$clog2(CODE_LEN):0]      digit_idx,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left
);

  localparam int CODE_W = code_w(CODE_LEN, DIGIT_W);
  localparam int IW     = $clog2(CODE_LEN) + 1;
  localparam int TW     = $clog2(MAX_TRIES + 1);
  localparam int LW     = LOCKOUT_CYCLES > 1 ? $clog2(LOCKOUT_CYCLES) : 1;

  state_t             st;
  state_t             state_nxt;
  logic [CODE_W-1:0]  code;
  logic [CODE_W-1:0]  shadow;
  logic [CODE_W-1:0]  shadow_nxt;
  logic [DIGIT_W-1:0] cur_digit;
  logic               mismatch;
  logic               mis_nxt;
  logic               last;
  logic               chk_q;
  logic               set_q;
  logic               chk_p;
  logic               set_p;
  logic               adv;
  logic               tmr_load;
  logic               tmr_zero;
  logic               blink_nxt;

  assign state    = st;
  assign chk_p    = check_btn & ~chk_q;
  assign set_p    = set_btn & ~set_q & ~chk_p;
  assign last     = digit_idx == IW'(CODE_LEN - 1);
  assign mis_nxt  = mismatch | (digit_in != cur_digit);
  assign adv      = (st == S_ENTRY && chk_p) || (st == S_SET_ENTRY && set_p);
  assign tmr_load = st == S_ENTRY && state_nxt == S_LOCKOUT;

  blink_timer #(
    .CNT_W(BLINK_BIT + 1),
    .TMR_W(LW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (LW'(LOCKOUT_CYCLES - 1)),
    .en       (st == S_LOCKOUT),
    .blink_nxt(blink_nxt),
    .tmr_zero (tmr_zero)
  );

  // Select the stored digit under test and build the shadow code with the incoming digit merged in
  always_comb begin
    cur_digit  = '0;
    shadow_nxt = shadow;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (digit_idx == IW'(i)) begin
        cur_digit                         = code[i*DIGIT_W +: DIGIT_W];
        shadow_nxt[i*DIGIT_W +: DIGIT_W] = digit_in;
      end
    end
  end

  // Next-state decode; check wins over set, and unknown encodings fall back to idle
  always_comb begin
    state_nxt = S_IDLE;
    case (st)
      S_IDLE:      state_nxt = chk_p ? S_ENTRY : S_IDLE;
      S_ENTRY:     state_nxt = !(chk_p && last) ? S_ENTRY :
                               !mis_nxt ? S_OPENED :
                               tries_left > TW'(1) ? S_ALARM : S_LOCKOUT;
      S_OPENED:    state_nxt = chk_p ? S_IDLE : set_p ? S_SET_ENTRY : S_OPENED;
      S_SET_ENTRY: state_nxt = chk_p ? S_OPENED : (set_p && last) ? S_IDLE : S_SET_ENTRY;
      S_ALARM:     state_nxt = chk_p ? S_IDLE : S_ALARM;
      S_LOCKOUT:   state_nxt = tmr_zero ? S_IDLE : S_LOCKOUT;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // State, datapath registers and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= S_IDLE;
      code       <= RESET_CODE;
      shadow     <= '0;
      digit_idx  <= '0;
      tries_left <= TW'(MAX_TRIES);
      mismatch   <= 1'b0;
      chk_q      <= 1'b0;
      set_q      <= 1'b0;
      opened     <= 1'b0;
      alarm      <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      chk_q      <= check_btn;
      set_q      <= set_btn;
      st         <= state_nxt;
      digit_idx  <= state_nxt != st ? '0 : adv ? digit_idx + IW'(1) : digit_idx;
      mismatch   <= st == S_IDLE ? 1'b0 : (st == S_ENTRY && chk_p) ? mis_nxt : mismatch;
      tries_left <= (st == S_ENTRY && state_nxt == S_OPENED) ? TW'(MAX_TRIES) :
                    (st == S_LOCKOUT && state_nxt == S_IDLE) ? TW'(MAX_TRIES) :
                    (st == S_ENTRY && state_nxt == S_ALARM) ? tries_left - TW'(1) :
                    (st == S_ENTRY && state_nxt == S_LOCKOUT) ? '0 : tries_left;
      shadow     <= (st == S_SET_ENTRY && set_p) ? shadow_nxt : shadow;
      code       <= (st == S_SET_ENTRY && set_p && last) ? shadow_nxt : code;
      opened     <= state_nxt == S_OPENED;
      locked_out <= state_nxt == S_LOCKOUT;
      alarm      <= (state_nxt == S_ALARM || state_nxt == S_LOCKOUT) && blink_nxt;
    end
  end

endmodule

// File: tb/tb_code_lock_fsm.sv
// tb_code_lock_fsm: scoreboard bench for the code lock
module tb_code_lock_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] digit_in = '0;
  logic       check_btn = 1'b0;
  logic       set_btn = 1'b0;
  logic       opened;
  logic       alarm;
  logic       locked_out;
  logic [2:0] state;
  logic [2:0] digit_idx;
  logic [1:0] tries_left;

  int total = 0;
  int bad = 0;
  int n = 0;

  typedef struct {
    string tag;
    int    sel;
    int    v;
  } exp_t;

  exp_t sb[$];

  code_lock_fsm #(
    .DIGIT_W(7),
    .CODE_LEN(4),
    .MAX_TRIES(3),
    .LOCKOUT_CYCLES(16),
    .BLINK_BIT(2),
    .RESET_CODE('0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .digit_in(digit_in),
    .check_btn(check_btn),
    .set_btn(set_btn),
    .opened(opened),
    .alarm(alarm),
    .locked_out(locked_out),
    .state(state),
    .digit_idx(digit_idx),
    .tries_left(tries_left)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) n <= 0;
    else n <= n + 1;
  end

  function automatic int obs(input int sel);
    case (sel)
      0: return int'(state);
      1: return int'(opened);
      2: return int'(alarm);
      3: return int'(locked_out);
      4: return int'(digit_idx);
      default: return int'(tries_left);
    endcase
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic push(input int sel, input int v, input string tag);
    sb.push_back('{tag, sel, v});
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, obs(e.sel), e.v);
    end
  endtask

  task automatic step(input bit c, input bit s, input int d);
    @(negedge clk);
    check_btn = c;
    set_btn = s;
    digit_in = 7'(d);
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic pr(input bit c, input bit s, input int d);
    step(c, s, d);
    step(1'b0, 1'b0, d);
  endtask

  task automatic enter(input int d[4], input bit set_mode, input int fs);
    for (int i = 0; i < 4; i++) begin
      push(4, i == 3 ? 0 : i + 1, "digit_idx");
      push(0, i == 3 ? fs : (set_mode ? 4 : 1), "state");
      pr(!set_mode, set_mode, d[i]);
    end
  endtask

  function automatic int blink_exp();
    return ((n + 1) >> 2) & 1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    rst = 1'b0;
    @(posedge clk);
    #1;
    push(0, 0, "rst_state"); push(1, 0, "rst_opened"); push(2, 0, "rst_alarm");
    push(3, 0, "rst_locked"); push(4, 0, "rst_idx"); push(5, 3, "rst_tries");
    drain();

    push(0, 1, "to_entry"); push(4, 0, "entry_idx");
    pr(1, 0, 0);
    enter('{0, 0, 0, 0}, 1'b0, 2);
    push(1, 1, "opened"); push(5, 3, "tries_open"); drain();

    push(0, 4, "to_set"); push(1, 0, "set_not_opened");
    pr(0, 1, 0);
    enter('{5, 6, 7, 8}, 1'b1, 0);

    push(0, 1, "reentry"); pr(1, 0, 0);
    enter('{5, 6, 7, 8}, 1'b0, 2);
    push(1, 1, "new_code_opens"); drain();
    push(0, 0, "open_to_idle"); pr(1, 0, 0);

    pr(1, 0, 0);
    enter('{0, 0, 0, 0}, 1'b0, 3);
    push(5, 2, "tries_after_alarm"); push(1, 0, "alarm_not_open"); drain();
    for (int i = 0; i < 8; i++) begin
      push(2, blink_exp(), "alarm_blink");
      push(0, 3, "alarm_hold");
      step(1'b0, i[0], 0);
    end
    push(0, 0, "alarm_to_idle"); push(5, 2, "tries_kept");
    pr(1, 0, 0);

    pr(1, 0, 0);
    enter('{5, 6, 7, 8}, 1'b0, 2);
    push(5, 3, "tries_restored"); drain();
    pr(1, 0, 0);

    for (int t = 0; t < 3; t++) begin
      pr(1, 0, 0);
      enter('{1, 1, 1, 1}, 1'b0, t == 2 ? 5 : 3);
      push(5, t == 2 ? 0 : 2 - t, "wrong_tries");
      drain();
      if (t < 2) begin
        push(0, 0, "wrong_to_idle");
        pr(1, 0, 0);
      end
    end
    push(3, 1, "locked_out"); drain();
    for (int k = 2; k <= 15; k++) begin
      push(0, 5, "lockout_hold");
      push(3, 1, "lockout_flag");
      push(2, blink_exp(), "lockout_blink");
      step(k % 2 == 1, (k / 2) % 2 == 1, 5);
    end
    push(0, 0, "lockout_end"); push(5, 3, "lockout_tries"); push(3, 0, "lockout_clear");
    step(1'b0, 1'b0, 0);

    pr(1, 0, 0);
    enter('{5, 6, 7, 8}, 1'b0, 2);
    push(0, 4, "set_abort_start"); pr(0, 1, 0);
    push(4, 1, "set_idx1"); pr(0, 1, 9);
    push(4, 2, "set_idx2"); pr(0, 1, 9);
    push(0, 2, "set_abort"); push(4, 0, "abort_idx"); pr(1, 0, 0);
    push(0, 0, "open_idle"); pr(1, 0, 0);
    pr(1, 0, 0);
    enter('{5, 6, 7, 8}, 1'b0, 2);
    push(0, 0, "both_btn_idle"); pr(1, 1, 0);

    for (int i = 0; i < 10; i++) begin
      push(0, 1, "hold_entry");
      push(4, 0, "hold_idx");
      step(1'b1, 1'b0, 3);
    end
    step(1'b0, 1'b0, 0);
    pr(1, 0, 0);
    push(4, 2, "mid_idx"); pr(1, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    push(0, 0, "async_rst_state"); push(4, 0, "async_rst_idx"); drain();
    @(negedge clk);
    rst = 1'b0;
    pr(1, 0, 0);
    enter('{0, 0, 0, 0}, 1'b0, 2);
    push(1, 1, "reset_code_restored"); drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
